// File: rtl/led_sequencer.sv
// led_sequencer: autonomous 8-LED pattern generator (static / blink / scan)
// gated by a 15-cycle PWM brightness stage, configured over a valid/ready port.
module led_sequencer #(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_mode,
    input  logic [7:0] cfg_pattern,
    input  logic [3:0] cfg_rate,
    input  logic [3:0] cfg_duty,
    output logic [7:0] led,
    output logic       step
);

    // state  | meaning
    // S_IDLE | nothing running, LEDs dark, config accepted
    // S_LOAD | single cycle: timers restart, shadow config becomes the frame
    // S_RUN  | frame steps every (rate+1) base ticks, config accepted (aborts)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_SCAN  = 2'd3;

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t        r_state;
    logic [1:0]    r_mode;
    logic [7:0]    r_pattern;
    logic [3:0]    r_rate;
    logic [3:0]    r_duty;
    logic [7:0]    r_frame;
    logic [7:0]    r_led;
    logic          r_step;
    logic [TW-1:0] r_tick_cnt;
    logic [3:0]    r_rate_cnt;
    logic [3:0]    r_pwm_cnt;

    logic          w_accept;
    logic          w_tick_wrap;
    logic          w_step_evt;
    logic          w_pwm_on;
    logic [7:0]    w_pwm_mask;
    logic [7:0]    w_frame_step;

    assign cfg_ready   = (r_state != S_LOAD);
    assign w_accept    = cfg_valid && cfg_ready;
    assign w_tick_wrap = (r_tick_cnt == TICK_LAST);
    assign w_step_evt  = (r_state == S_RUN) && w_tick_wrap && (r_rate_cnt == r_rate);
    assign w_pwm_on    = (r_duty == 4'd15) || (r_pwm_cnt < r_duty);
    assign w_pwm_mask  = {8{w_pwm_on}};

    // XOR with the captured pattern alternates pattern / 0 for any pattern value
    always_comb begin
        w_frame_step = r_frame;
        case (r_mode)
            MODE_BLINK: w_frame_step = r_frame ^ r_pattern;
            MODE_SCAN:  w_frame_step = {r_frame[6:0], r_frame[7]};
            default:    w_frame_step = r_frame;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_rate_cnt <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == 4'd14) ? 4'd0 : r_pwm_cnt + 4'd1;
            if (r_state == S_LOAD) begin
                r_tick_cnt <= '0;
                r_rate_cnt <= '0;
                r_pwm_cnt  <= '0;
            end else if (w_tick_wrap) begin
                r_tick_cnt <= '0;
                r_rate_cnt <= (r_rate_cnt >= r_rate) ? 4'd0 : r_rate_cnt + 4'd1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= MODE_OFF;
            r_pattern <= '0;
            r_rate    <= '0;
            r_duty    <= '0;
            r_frame   <= '0;
            r_led     <= '0;
            r_step    <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (w_accept) begin
                r_mode    <= cfg_mode;
                r_pattern <= cfg_pattern;
                r_rate    <= cfg_rate;
                r_duty    <= cfg_duty;
            end
            case (r_state)
                S_IDLE: begin
                    r_led <= '0;
                    if (w_accept) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (r_mode == MODE_OFF) begin
                        r_state <= S_IDLE;
                        r_frame <= '0;
                        r_led   <= '0;
                    end else begin
                        r_state <= S_RUN;
                        r_frame <= r_pattern;
                        r_led   <= r_pattern & w_pwm_mask;
                    end
                end
                S_RUN: begin
                    // an accept beats a coincident step: old frame held through LOAD
                    if (w_accept) begin
                        r_state <= S_LOAD;
                        r_led   <= r_frame & w_pwm_mask;
                    end else if (w_step_evt) begin
                        r_frame <= w_frame_step;
                        r_led   <= w_frame_step & w_pwm_mask;
                        r_step  <= 1'b1;
                    end else begin
                        r_led <= r_frame & w_pwm_mask;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_led   <= '0;
                end
            endcase
        end
    end

    assign led  = r_led;
    assign step = r_step;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: cycle-level arithmetic model checked every cycle,
// plus directed scenarios with hand-computed LED values.
module tb_led_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic [7:0] cfg_pattern = 8'd0;
    logic [3:0] cfg_rate = 4'd0;
    logic [3:0] cfg_duty = 4'd0;
    logic       cfg_ready;
    logic [7:0] led;
    logic       step;

    int n_tests = 0;
    int n_fail  = 0;

    led_sequencer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_pattern(cfg_pattern),
        .cfg_rate   (cfg_rate),
        .cfg_duty   (cfg_duty),
        .led        (led),
        .step       (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Frame after k step periods since load, from the mode's definition.
    function automatic logic [7:0] frame_of(input logic [1:0] mode, input logic [7:0] pat, input int k);
        logic [15:0] d;
        d = {pat, pat} << (k % 8);
        case (mode)
            2'd1:    return pat;
            2'd2:    return (k % 2 != 0) ? 8'h00 : pat;
            2'd3:    return d[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic pwm_on_f(input int cnt, input logic [3:0] duty);
        return (duty == 4'd15) || (cnt < int'(duty));
    endfunction

    // Model: m_e counts edges since reset release; m_e1 is the last LOAD edge,
    // m_clr the last PWM restart. m_state: 0 idle, 1 load, 2 run.
    int         m_e = 0, m_e1 = 0, m_clr = 0, m_state = 0, mp = 1;
    logic       mon;
    logic [1:0] m_mode = 2'd0;
    logic [7:0] m_pat = 8'd0;
    logic [3:0] m_rate = 4'd0, m_duty = 4'd0;
    logic [7:0] m_exp_led = 8'd0;
    logic       m_exp_step = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0; m_e1 = 0; m_clr = 0; m_state = 0;
            m_mode = 2'd0; m_pat = 8'd0; m_rate = 4'd0; m_duty = 4'd0;
            m_exp_led = 8'd0; m_exp_step = 1'b0;
        end else begin
            mp  = (int'(m_rate) + 1) * TD;
            mon = pwm_on_f((m_e - m_clr) % 15, m_duty);
            m_e = m_e + 1;
            m_exp_step = 1'b0;
            case (m_state)
                0: begin
                    m_exp_led = 8'h00;
                    if (cfg_valid) begin
                        m_mode = cfg_mode; m_pat = cfg_pattern; m_rate = cfg_rate; m_duty = cfg_duty;
                        m_state = 1;
                    end
                end
                1: begin
                    m_e1 = m_e;
                    m_clr = m_e;
                    if (m_mode == 2'd0) begin
                        m_state = 0;
                        m_exp_led = 8'h00;
                    end else begin
                        m_state = 2;
                        m_exp_led = m_pat & {8{mon}};
                    end
                end
                default: begin
                    if (cfg_valid) begin
                        m_exp_led = frame_of(m_mode, m_pat, (m_e - 1 - m_e1) / mp) & {8{mon}};
                        m_mode = cfg_mode; m_pat = cfg_pattern; m_rate = cfg_rate; m_duty = cfg_duty;
                        m_state = 1;
                    end else begin
                        m_exp_led  = frame_of(m_mode, m_pat, (m_e - m_e1) / mp) & {8{mon}};
                        m_exp_step = ((m_e - m_e1) % mp == 0);
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("model_led", led, m_exp_led);
        check("model_step", {7'd0, step}, {7'd0, m_exp_step});
        check("model_ready", {7'd0, cfg_ready}, {7'd0, m_state != 1});
    end

    // Called at a negedge while the DUT is ready; returns at the negedge after
    // the LOAD edge. Garbage with valid high during LOAD must be ignored.
    task automatic do_accept(input logic [1:0] mode, input logic [7:0] pat, input logic [3:0] rate,
                             input logic [3:0] duty, input logic check_hold, input logic [7:0] hold_exp);
        cfg_valid = 1'b1;
        cfg_mode = mode; cfg_pattern = pat; cfg_rate = rate; cfg_duty = duty;
        @(posedge clk);
        @(negedge clk);
        check("load_ready", {7'd0, cfg_ready}, 8'h00);
        check("load_step", {7'd0, step}, 8'h00);
        if (check_hold) check("load_hold_frame", led, hold_exp);
        cfg_mode = ~mode; cfg_pattern = ~pat; cfg_rate = rate + 4'd3; cfg_duty = ~duty;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_mode = 2'($urandom); cfg_pattern = 8'($urandom);
        cfg_rate = 4'($urandom); cfg_duty = 4'($urandom);
    endtask

    logic [7:0] scan_exp [0:8];
    int         cnt_a, cnt_b;
    logic [7:0] acc;

    initial begin
        scan_exp = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

        repeat (3) @(negedge clk);
        check("reset_led", led, 8'h00);
        check("reset_ready", {7'd0, cfg_ready}, 8'h01);
        check("reset_step", {7'd0, step}, 8'h00);
        rst_n = 1'b1;
        cnt_a = 0; acc = 8'h00;
        repeat (100) begin
            @(negedge clk);
            cnt_a += int'(step);
            acc |= led;
        end
        check("idle_steps", 8'(cnt_a), 8'd0);
        check("idle_led", acc, 8'h00);

        // STATIC A5, rate 1: step every 8 cycles, LEDs constant
        do_accept(2'd1, 8'hA5, 4'd1, 4'd15, 1'b0, 8'h00);
        check("static_led", led, 8'hA5);
        cnt_a = 0; cnt_b = 0;
        repeat (32) begin
            @(negedge clk);
            cnt_a += int'(step);
            if (led != 8'hA5) cnt_b++;
        end
        check("static_steps", 8'(cnt_a), 8'd4);
        check("static_changes", 8'(cnt_b), 8'd0);

        // BLINK 0F, rate 1: 0F for 8 cycles, then 00, then 0F
        do_accept(2'd2, 8'h0F, 4'd1, 4'd15, 1'b0, 8'h00);
        check("blink_first", led, 8'h0F);
        repeat (7) @(negedge clk);
        check("blink_hold", led, 8'h0F);
        @(negedge clk);
        check("blink_off", led, 8'h00);
        check("blink_step", {7'd0, step}, 8'h01);
        repeat (8) @(negedge clk);
        check("blink_on", led, 8'h0F);

        // SCAN 81, rate 0: rotate left every 4 cycles, bit 7 wraps to bit 0
        do_accept(2'd3, 8'h81, 4'd0, 4'd15, 1'b0, 8'h00);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("scan_%0d", k), led, scan_exp[k]);
            repeat (4) @(negedge clk);
        end

        // PWM: duty 5 lights 5 of 15 cycles, duty 0 never lights
        do_accept(2'd1, 8'hFF, 4'd15, 4'd5, 1'b0, 8'h00);
        cnt_a = 0; cnt_b = 0;
        repeat (15) begin
            @(negedge clk);
            if (led == 8'hFF) cnt_a++;
            if (led == 8'h00) cnt_b++;
        end
        check("pwm5_on", 8'(cnt_a), 8'd5);
        check("pwm5_off", 8'(cnt_b), 8'd10);
        do_accept(2'd1, 8'hFF, 4'd15, 4'd0, 1'b0, 8'h00);
        acc = 8'h00;
        repeat (15) begin
            @(negedge clk);
            acc |= led;
        end
        check("pwm0_dark", acc, 8'h00);

        // Accept on the same edge as a step event: frame 02 held, no step
        do_accept(2'd3, 8'h01, 4'd0, 4'd15, 1'b0, 8'h00);
        repeat (7) @(negedge clk);
        do_accept(2'd1, 8'h3C, 4'd2, 4'd15, 1'b1, 8'h02);
        check("reconfig_led", led, 8'h3C);

        do_accept(2'd0, 8'hFF, 4'd3, 4'd15, 1'b0, 8'h00);
        check("off_led", led, 8'h00);
        check("off_ready", {7'd0, cfg_ready}, 8'h01);
        repeat (20) @(negedge clk);

        // Async reset mid-SCAN clears LEDs before any clock edge
        do_accept(2'd3, 8'h81, 4'd0, 4'd15, 1'b0, 8'h00);
        repeat (6) @(negedge clk);
        check("pre_reset_led", led, 8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_led", led, 8'h00);
        check("async_reset_ready", {7'd0, cfg_ready}, 8'h01);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
